// File: rtl/bit_serial_adder_if.sv
// ----------------------------------------------------------------------------
// bit_serial_adder_if
//
// Groups the request/response signals of bit_serial_adder into one bundle.
//
// Signals:
//   start  - request to begin an addition (honoured only while the adder idles)
//   a, b   - WIDTH-bit operands, captured on the accepting edge
//   cin    - carry-in, captured on the accepting edge
//   sub    - subtract request (only when BIT_SERIAL_ADDER_SUB_EN is defined)
//   busy   - adder is working on an operation
//   done   - one-cycle pulse: sum/cout hold a fresh result
//   sum    - registered result, held between completions
//   cout   - registered final carry-out
//
// Modports:
//   master - the requester (drives start/a/b/cin/sub)
//   slave  - the adder itself
//
// Optional feature macro: BIT_SERIAL_ADDER_SUB_EN (adds the sub signal).
// ----------------------------------------------------------------------------
interface bit_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef BIT_SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef BIT_SERIAL_ADDER_SUB_EN
    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout
    );
`else
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
`endif
endinterface

// File: rtl/bit_serial_adder.sv
// ----------------------------------------------------------------------------
// bit_serial_adder
//
// Adds two WIDTH-bit operands LSB-first, one bit per clock, through a single
// full-adder cell and a registered carry. The result is reassembled in a shift
// register and presented in parallel along with a one-cycle done pulse.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - bit_serial_adder_if.slave
//          inputs : start, a, b, cin (and sub when subtraction is built in)
//          outputs: busy, done, sum, cout (all registered)
//
// Parameters:
//   WIDTH - operand/result width, >= 1
//
// Optional feature macro: BIT_SERIAL_ADDER_SUB_EN
//   When defined, bus.sub = 1 at the accepting edge makes the block compute
//   a - b (mod 2^WIDTH) by adding ~b with a forced carry-in of 1; cout = 1
//   then means "no borrow". When undefined the block is add-only.
//
// Timing (start accepted at edge k):
//   edges k+1 .. k+WIDTH : one operand bit per edge (SHIFT)
//   edge  k+WIDTH        : sum/cout loaded, done rises
//   edge  k+WIDTH+1      : back to IDLE, busy falls
// ----------------------------------------------------------------------------
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    bit_serial_adder_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Full-adder cell: sum bit
    function automatic logic fa_sum(input logic x, input logic y, input logic z);
        return x ^ y ^ z;
    endfunction

    // Full-adder cell: carry bit (majority of the three inputs)
    function automatic logic fa_carry(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] sum_sh_r;
    logic [WIDTH-1:0] sum_sh_s;
    logic             carry_r;
    logic [CNT_W-1:0] cnt_r;
    logic             bit_sum_s;
    logic             bit_carry_s;
    logic             last_bit_s;
    logic [WIDTH-1:0] b_load_s;
    logic             carry_load_s;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;

    // Full-adder cell fed from the LSBs of the operand shifters
    always_comb begin
        bit_sum_s   = fa_sum(a_sh_r[0], b_sh_r[0], carry_r);
        bit_carry_s = fa_carry(a_sh_r[0], b_sh_r[0], carry_r);
        // New sum bit enters at the MSB so that after WIDTH shifts the
        // first (LSB) result bit has walked down to position 0.
        sum_sh_s    = (sum_sh_r >> 1) | (WIDTH'(bit_sum_s) << (WIDTH - 1));
        last_bit_s  = (cnt_r == CNT_W'(WIDTH - 1));
    end

    // Operand B and initial carry as captured on the accepting edge
    always_comb begin
`ifdef BIT_SERIAL_ADDER_SUB_EN
        if (bus.sub) begin
            // Two's complement subtraction: a + ~b + 1; cin is ignored.
            b_load_s     = ~bus.b;
            carry_load_s = 1'b1;
        end else begin
            b_load_s     = bus.b;
            carry_load_s = bus.cin;
        end
`else
        b_load_s     = bus.b;
        carry_load_s = bus.cin;
`endif
    end

    // Next-state logic for the IDLE -> SHIFT -> DONE sequence
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_bit_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                // start is not queued: DONE always returns to IDLE first.
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register; busy/done are registered from the next state so they
    // line up exactly with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
        end
    end

    // Operand shifters, carry, bit counter and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            sum_sh_r <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            sum_r    <= {WIDTH{1'b0}};
            cout_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        a_sh_r   <= bus.a;
                        b_sh_r   <= b_load_s;
                        carry_r  <= carry_load_s;
                        sum_sh_r <= {WIDTH{1'b0}};
                        cnt_r    <= {CNT_W{1'b0}};
                    end
                end
                SHIFT: begin
                    a_sh_r   <= a_sh_r >> 1;
                    b_sh_r   <= b_sh_r >> 1;
                    sum_sh_r <= sum_sh_s;
                    carry_r  <= bit_carry_s;
                    cnt_r    <= cnt_r + CNT_W'(1);
                    // The visible result only moves on the final bit, so it
                    // stays stable while the next operation is computing.
                    if (last_bit_s) begin
                        sum_r  <= sum_sh_s;
                        cout_r <= bit_carry_s;
                    end
                end
                DONE: begin
                    // Hold everything; result is already captured.
                end
                default: begin
                    // Unreachable encodings: hold; next state returns to IDLE.
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;

endmodule

// File: tb/tb_bit_serial_adder.sv
// ----------------------------------------------------------------------------
// tb_bit_serial_adder
//
// Directed, table-driven bench for bit_serial_adder (WIDTH = 8). Each table
// entry is one operation with hand-computed sum/cout; every cycle of each
// operation checks busy, done and the held/new result. Hand-written sequences
// cover start re-pulsed mid-operation, start held high and reset mid-SHIFT.
// ----------------------------------------------------------------------------
module tb_bit_serial_adder;

    localparam int WIDTH = 8;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
    } vec_t;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] prev_sum;
    logic             prev_cout;

    bit_serial_adder_if #(.WIDTH(WIDTH)) bus ();

    bit_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Runs one operation. Must be called at a negedge; returns at the negedge
    // after the edge that brings the adder back to IDLE, so calls chain at
    // maximum throughput. poke: cycle index at which start is re-pulsed with
    // other operands (-1 = never). hold: keep start high and operands fixed.
    task automatic run_op(input vec_t v, input int poke, input bit hold);
        bus.start = 1'b1;
        bus.a     = v.a;
        bus.b     = v.b;
        bus.cin   = v.cin;
`ifdef BIT_SERIAL_ADDER_SUB_EN
        bus.sub   = v.sub;
`endif
        @(posedge clk); // accepting edge k
        for (int i = 0; i <= WIDTH + 1; i++) begin
            @(negedge clk); // after edge k+i
            if (!hold) begin
                if (i == poke) begin
                    bus.start = 1'b1;
                    bus.a     = ~v.a;
                    bus.b     = 8'h11;
                    bus.cin   = ~v.cin;
                end else begin
                    bus.start = 1'b0;
                    bus.a     = WIDTH'($urandom);
                    bus.b     = WIDTH'($urandom);
                    bus.cin   = 1'($urandom);
                end
            end
            check({v.name, " busy"}, 32'(bus.busy), 32'(i <= WIDTH));
            check({v.name, " done"}, 32'(bus.done), 32'(i == WIDTH));
            if (i < WIDTH) begin
                check({v.name, " sum held"},  32'(bus.sum),  32'(prev_sum));
                check({v.name, " cout held"}, 32'(bus.cout), 32'(prev_cout));
            end else begin
                check({v.name, " sum"},  32'(bus.sum),  32'(v.exp_sum));
                check({v.name, " cout"}, 32'(bus.cout), 32'(v.exp_cout));
            end
        end
        prev_sum  = v.exp_sum;
        prev_cout = v.exp_cout;
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;
        int   done_seen;

        vecs.push_back('{"3c+5a",    8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0});
        vecs.push_back('{"ff+01",    8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{"ff+00+1",  8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{"00+00",    8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{"12+34+1",  8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0});
        vecs.push_back('{"aa+55",    8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0});
        vecs.push_back('{"aa+55+1",  8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{"7f+01",    8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0});
`ifdef BIT_SERIAL_ADDER_SUB_EN
        vecs.push_back('{"05-07",    8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0});
        vecs.push_back('{"07-05",    8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1});
        vecs.push_back('{"07-05 ci", 8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1});
        vecs.push_back('{"a0+0f s0", 8'hA0, 8'h0F, 1'b1, 1'b0, 8'hB0, 1'b0});
`endif
        // Last entry leaves a non-zero sum and cout=1 for the reset check.
        vecs.push_back('{"80+81",    8'h80, 8'h81, 1'b0, 1'b0, 8'h01, 1'b1});

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
`ifdef BIT_SERIAL_ADDER_SUB_EN
        bus.sub   = 1'b0;
`endif
        prev_sum  = 8'h00;
        prev_cout = 1'b0;

        repeat (2) @(negedge clk);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset sum",  32'(bus.sum),  32'd0);
        check("reset cout", 32'(bus.cout), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table: every operation back-to-back at maximum throughput.
        foreach (vecs[i]) begin
            run_op(vecs[i], -1, 1'b0);
        end

        // start re-pulsed mid-SHIFT and during DONE: both ignored.
        v = '{"repoke shift", 8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0};
        run_op(v, 3, 1'b0);
        v = '{"repoke done",  8'h21, 8'h43, 1'b1, 1'b0, 8'h65, 1'b0};
        run_op(v, WIDTH, 1'b0);

        // start held high: next acceptance only on the cycle after DONE.
        v = '{"hold op1", 8'hC8, 8'h64, 1'b0, 1'b0, 8'h2C, 1'b1};
        run_op(v, -1, 1'b1);
        v = '{"hold op2", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0};
        run_op(v, -1, 1'b0);

        // Leave a non-zero result, then reset in the 4th SHIFT cycle.
        v = '{"pre-reset", 8'h80, 8'h81, 1'b0, 1'b0, 8'h01, 1'b1};
        run_op(v, -1, 1'b0);
        bus.start = 1'b1;
        bus.a     = 8'h3C;
        bus.b     = 8'h5A;
        bus.cin   = 1'b0;
        @(posedge clk);          // edge k
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(posedge clk); // edges k+1..k+3 -> 4th SHIFT cycle
        @(negedge clk);
        check("mid busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort sum",  32'(bus.sum),  32'd0);
        check("abort cout", 32'(bus.cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check("no done after abort", 32'(done_seen), 32'd0);
        prev_sum  = 8'h00;
        prev_cout = 1'b0;
        v = '{"post-reset", 8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0};
        run_op(v, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
